vdp_cmd_engine: RTL and testbench

VDP_CMD_ENGINE -- requirements
Module: vdp_cmd_engine

---
 rtl/vdp_cmd_engine_if.sv | 10 +
 rtl/vdp_cmd_engine.sv | 169 ++++++++++++++++
 tb/tb_vdp_cmd_engine.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vdp_cmd_engine_if.sv
// rtl/vdp_cmd_engine_if.sv - CPU register-write bus into the VDP command engine
interface vdp_cmd_engine_if;
    logic       WR_VALID;
    logic [2:0] WR_REG;
    logic [7:0] WR_DATA;
    logic       WR_READY;

    modport master (output WR_VALID, WR_REG, WR_DATA, input WR_READY);
    modport slave  (input WR_VALID, WR_REG, WR_DATA, output WR_READY);
endinterface

// File: rtl/vdp_cmd_engine.sv
// rtl/vdp_cmd_engine.sv - VDP command FIFO and VRAM access engine
// Define VDP_READBACK_EN to enable the READ register (VRAM read-back).
module vdp_cmd_engine #(
    parameter int ADDR_W    = 14,
    parameter int FIFO_AW   = 4,
    parameter int VRAM_SIZE = 'h2000,
    parameter int H_CHARS   = 80
) (
    input  logic                CLK,
    input  logic                RESET_N,
    vdp_cmd_engine_if.slave     wr,
    input  logic                BLANK,
    output logic                VRAM_WE,
    output logic [ADDR_W-1:0]   VRAM_ADDR,
    output logic [7:0]          VRAM_WDATA,
    input  logic [7:0]          VRAM_RDATA,
    output logic [1:0]          MODE,
    output logic [ADDR_W-1:0]   ADDR,
    output logic [FIFO_AW:0]    FIFO_COUNT,
    output logic                OVERFLOW,
    output logic [7:0]          RD_DATA,
    output logic                RD_VALID
);
    localparam int              DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);
    localparam logic [ADDR_W:0]  VSIZE    = (ADDR_W+1)'(VRAM_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        WAIT_BLANK,
`ifdef VDP_READBACK_EN
        READ_WAIT,
`endif
        INC
    } state_t;

    state_t             state;
    logic [10:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [2:0]         cmd_reg;
    logic [7:0]         cmd_data;
    logic [4:0]         inc_code;
    logic               neg;
    logic               push, drop, pop, in_range, wr_go;
    logic [ADDR_W:0]    inc_v, a_ext;
    logic [ADDR_W-1:0]  a_next;

    function automatic logic [ADDR_W:0] inc_of(input logic [4:0] code);
        logic [ADDR_W:0] v;
        v = '0;
        if (code >= 5'd1 && code <= 5'd8) begin
            v = (ADDR_W+1)'(1) << (code - 5'd1);
        end else begin
            case (code)
                5'd9:    v = (ADDR_W+1)'(3);
                5'd10:   v = (ADDR_W+1)'(10);
                5'd11:   v = (ADDR_W+1)'(H_CHARS);
                5'd12:   v = (ADDR_W+1)'(2 * H_CHARS);
                5'd13:   v = (ADDR_W+1)'(3 * H_CHARS);
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    assign wr.WR_READY = (FIFO_COUNT != FULL_CNT);
    assign push        = wr.WR_VALID && wr.WR_READY;
    assign drop        = wr.WR_VALID && !wr.WR_READY;
    assign pop         = (state == IDLE) && (FIFO_COUNT != '0);
    assign in_range    = {1'b0, ADDR} < VSIZE;

    // The write strobe follows the live BLANK so a write can never land outside blanking.
    assign wr_go      = (state == EXEC || state == WAIT_BLANK) && (cmd_reg == 3'd3) && BLANK;
    assign VRAM_WE    = wr_go && in_range;
    assign VRAM_ADDR  = ADDR;
    assign VRAM_WDATA = cmd_data;

    always_comb begin
        inc_v  = inc_of(inc_code);
        a_ext  = {1'b0, ADDR};
        a_next = ADDR;
        if (inc_v != '0) begin
            if (!neg)
                a_next = ADDR_W'((a_ext + inc_v) % VSIZE);
            else if (a_ext >= inc_v)
                a_next = ADDR_W'(a_ext - inc_v);
            else
                a_next = ADDR_W'(a_ext + VSIZE - inc_v);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= {wr.WR_REG, wr.WR_DATA};
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            FIFO_COUNT <= '0;
            cmd_reg    <= '0;
            cmd_data   <= '0;
            MODE       <= 2'd1;
            inc_code   <= 5'd1;
            neg        <= 1'b0;
            ADDR       <= '0;
            OVERFLOW   <= 1'b0;
`ifdef VDP_READBACK_EN
            RD_DATA    <= '0;
            RD_VALID   <= 1'b0;
`endif
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            FIFO_COUNT <= FIFO_COUNT + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
`ifdef VDP_READBACK_EN
            RD_VALID <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pop) begin
                        {cmd_reg, cmd_data} <= mem[rd_ptr];
                        state <= EXEC;
                    end
                end
                EXEC, WAIT_BLANK: begin
                    state <= IDLE;
                    case (cmd_reg)
                        3'd0: begin
                            MODE     <= cmd_data[1:0];
                            inc_code <= cmd_data[6:2];
                            neg      <= cmd_data[7];
                        end
                        3'd1: ADDR[7:0]        <= cmd_data;
                        3'd2: ADDR[ADDR_W-1:8] <= cmd_data[ADDR_W-9:0];
                        3'd3: state <= BLANK ? INC : WAIT_BLANK;
                        3'd4: OVERFLOW <= 1'b0;
`ifdef VDP_READBACK_EN
                        3'd5: state <= BLANK ? READ_WAIT : WAIT_BLANK;
`endif
                        default: ;
                    endcase
                end
`ifdef VDP_READBACK_EN
                READ_WAIT: begin
                    RD_DATA  <= VRAM_RDATA;
                    RD_VALID <= 1'b1;
                    state    <= INC;
                end
`endif
                INC: begin
                    ADDR  <= a_next;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A dropped push wins over a STATUS clear in the same cycle.
            if (drop) OVERFLOW <= 1'b1;
        end
    end

`ifndef VDP_READBACK_EN
    assign RD_DATA  = '0;
    assign RD_VALID = 1'b0;
    wire unused_rdata = ^VRAM_RDATA;
`endif
endmodule

// File: tb/tb_vdp_cmd_engine.sv
// tb/tb_vdp_cmd_engine.sv - self-checking bench for vdp_cmd_engine
module tb_vdp_cmd_engine;
    localparam int ADDR_W = 14, FIFO_AW = 4, VRAM_SIZE = 'h2000, H_CHARS = 80;

    logic              CLK = 1'b0, RESET_N = 1'b0, BLANK = 1'b1, mem_clr = 1'b1;
    logic              VRAM_WE, OVERFLOW, RD_VALID;
    logic [ADDR_W-1:0] VRAM_ADDR, ADDR;
    logic [7:0]        VRAM_WDATA, VRAM_RDATA, RD_DATA;
    logic [1:0]        MODE;
    logic [FIFO_AW:0]  FIFO_COUNT;

    vdp_cmd_engine_if bus();

    vdp_cmd_engine #(.ADDR_W(ADDR_W), .FIFO_AW(FIFO_AW), .VRAM_SIZE(VRAM_SIZE), .H_CHARS(H_CHARS)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .wr(bus), .BLANK(BLANK),
        .VRAM_WE(VRAM_WE), .VRAM_ADDR(VRAM_ADDR), .VRAM_WDATA(VRAM_WDATA), .VRAM_RDATA(VRAM_RDATA),
        .MODE(MODE), .ADDR(ADDR), .FIFO_COUNT(FIFO_COUNT), .OVERFLOW(OVERFLOW),
        .RD_DATA(RD_DATA), .RD_VALID(RD_VALID)
    );

    always #5 CLK = ~CLK;

    int checks = 0, errors = 0;
    int wlog[$], rlog[$], exp_w[$], exp_r[$];
    int rd_run = 0, max_run = 0;

    function automatic logic [7:0] pat(input int a);
        return 8'((a * 37 + 11) & 255);
    endfunction

    // VRAM behavioural memory: unwritten locations read back a fixed pattern.
    logic [7:0] vmem [16384];
    logic       vflag[16384];
    always @(posedge CLK) begin
        VRAM_RDATA <= vflag[VRAM_ADDR] ? vmem[VRAM_ADDR] : pat(int'(VRAM_ADDR));
        if (mem_clr) begin
            for (int i = 0; i < 16384; i++) vflag[i] <= 1'b0;
        end else if (VRAM_WE) begin
            vmem[VRAM_ADDR]  <= VRAM_WDATA;
            vflag[VRAM_ADDR] <= 1'b1;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RESET_N) begin
            if (VRAM_WE) begin
                chk("we_only_in_blank", int'(BLANK), 1);
                wlog.push_back(int'({VRAM_ADDR, VRAM_WDATA}));
            end
            if (RD_VALID) begin
                rlog.push_back(int'(RD_DATA));
                rd_run++;
                if (rd_run > max_run) max_run = rd_run;
            end else begin
                rd_run = 0;
            end
        end
    end

    // Reference model: register file, address rules and the expected VRAM traffic.
    int m_mode, m_code, m_neg, m_addr, m_ovf;
    int mw[int];

    function automatic int inc_val(input int c);
        if (c >= 1 && c <= 8) return 1 << (c - 1);
        case (c)
            9:       return 3;
            10:      return 10;
            11:      return H_CHARS;
            12:      return 2 * H_CHARS;
            13:      return 3 * H_CHARS;
            default: return 0;
        endcase
    endfunction

    task automatic m_reset();
        m_mode = 1; m_code = 1; m_neg = 0; m_addr = 0; m_ovf = 0;
    endtask

    task automatic m_step();
        int inc;
        inc = inc_val(m_code);
        if (inc == 0) return;
        if (m_neg == 0)        m_addr = (m_addr + inc) % VRAM_SIZE;
        else if (m_addr >= inc) m_addr = m_addr - inc;
        else                    m_addr = m_addr + VRAM_SIZE - inc;
    endtask

    task automatic m_apply(input int r, input int d);
        case (r)
            0: begin m_mode = d & 3; m_code = (d >> 2) & 31; m_neg = (d >> 7) & 1; end
            1: m_addr = (m_addr & ~255) | d;
            2: m_addr = (m_addr & 255) | ((d & 63) << 8);
            3: begin
                if (m_addr < VRAM_SIZE) begin
                    exp_w.push_back((m_addr << 8) | d);
                    mw[m_addr] = d;
                end
                m_step();
            end
            4: m_ovf = 0;
            5: begin
`ifdef VDP_READBACK_EN
                exp_r.push_back(mw.exists(m_addr) ? mw[m_addr] : int'(pat(m_addr)));
                m_step();
`endif
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic push_raw(input int r, input int d);
        bus.WR_VALID = 1'b1;
        bus.WR_REG   = r[2:0];
        bus.WR_DATA  = d[7:0];
        tick();
        bus.WR_VALID = 1'b0;
    endtask

    task automatic push(input int r, input int d);
        int n = 0;
        while (bus.WR_READY !== 1'b1 && n < 300) begin
            if (n > 20) BLANK = 1'b1;
            tick();
            n++;
        end
        if (n >= 300) chk("push_ready_timeout", int'(bus.WR_READY), 1);
        push_raw(r, d);
        m_apply(r, d);
    endtask

    task automatic drain();
        int n = 0;
        while (FIFO_COUNT != 0 && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) chk("drain_timeout", int'(FIFO_COUNT), 0);
        repeat (6) tick();
    endtask

    task automatic cmp_writes(input string tag);
        chk({tag, "_nwrites"}, wlog.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < wlog.size(); i++) chk(tag, wlog[i], exp_w[i]);
        wlog.delete();
        exp_w.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_ready"},   int'(bus.WR_READY), 1);
        chk({tag, "_fifo_count"}, int'(FIFO_COUNT), 0);
        chk({tag, "_mode"},       int'(MODE), 1);
        chk({tag, "_addr"},       int'(ADDR), 0);
        chk({tag, "_overflow"},   int'(OVERFLOW), 0);
        chk({tag, "_rd_data"},    int'(RD_DATA), 0);
        chk({tag, "_rd_valid"},   int'(RD_VALID), 0);
        chk({tag, "_vram_we"},    int'(VRAM_WE), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, d;
        bus.WR_VALID = 1'b0; bus.WR_REG = '0; bus.WR_DATA = '0;
        m_reset();
        tick();
        tick();
        mem_clr = 1'b0;
        chk_reset_outputs("reset");
        RESET_N = 1'b1;
        tick();

        // Sequential DATA writes with increment 1
        push(0, 'h04); push(1, 'h10);
        push(3, 'h41); push(3, 'h42); push(3, 'h43);
        drain();
        cmp_writes("seq_write");
        chk("seq_addr", int'(ADDR), 'h13);

        // Negative row-stride step wraps below zero
        push(0, 'hAC); push(2, 'h00); push(1, 'h20); push(3, 'h55);
        drain();
        cmp_writes("neg_write");
        chk("neg_addr", int'(ADDR), 'h1FD0);
        chk("neg_mode", int'(MODE), 0);

        // DATA held off while BLANK is low
        BLANK = 1'b0;
        push(0, 'h04); push(3, 'h7E);
        repeat (100) tick();
        chk("blank_hold_nwrites", wlog.size(), 0);
        BLANK = 1'b1;
        drain();
        cmp_writes("blank_release");
        chk("blank_addr", int'(ADDR), m_addr);

        // FIFO fill and overflow behind a stalled write
        BLANK = 1'b0;
        push(3, 'h11);
        repeat (5) tick();
        for (int i = 0; i < 17; i++) begin
            push_raw(3, 'h20 + i);
            if (i < 16) m_apply(3, 'h20 + i);
            else        m_ovf = 1;
        end
        chk("full_count", int'(FIFO_COUNT), 16);
        chk("full_ready", int'(bus.WR_READY), 0);
        chk("full_overflow", int'(OVERFLOW), m_ovf);
        BLANK = 1'b1;
        drain();
        cmp_writes("full_drain");
        push(4, 'h00);
        drain();
        chk("status_clear", int'(OVERFLOW), 0);

        // Address wrap at the top of VRAM, then reset during WAIT_BLANK
        push(2, 'h1F); push(1, 'hFF); push(0, 'h04); push(3, 'h5A);
        drain();
        cmp_writes("wrap_write");
        chk("wrap_addr", int'(ADDR), 0);
        BLANK = 1'b0;
        push_raw(3, 'h99);
        repeat (4) tick();
        RESET_N = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        m_reset();
        tick();
        RESET_N = 1'b1;
        BLANK   = 1'b1;
        repeat (10) tick();
        cmp_writes("midreset_nowrite");
        chk("midreset_count", int'(FIFO_COUNT), 0);

        // READ register
        rlog.delete(); exp_r.delete(); max_run = 0;
        push(2, 'h01); push(1, 'h00); push(3, 'h9C); push(1, 'h00); push(5, 'h00);
        drain();
        cmp_writes("read_setup");
`ifdef VDP_READBACK_EN
        chk("read_nvalid", rlog.size(), 1);
        if (rlog.size() > 0) chk("read_data", rlog[0], 'h9C);
        chk("read_pulse", max_run, 1);
        chk("read_addr", int'(ADDR), 'h101);
`else
        chk("read_nvalid", rlog.size(), 0);
        chk("read_data", int'(RD_DATA), 0);
        chk("read_addr", int'(ADDR), 'h100);
`endif
        rlog.delete(); exp_r.delete(); max_run = 0;

        // Randomized command stream against the model
        for (int k = 0; k < 120; k++) begin
            r = $urandom_range(0, 7);
            d = $urandom_range(0, 255);
            BLANK = ($urandom_range(0, 3) != 0);
            push(r, d);
        end
        BLANK = 1'b1;
        drain();
        cmp_writes("rand_write");
        chk("rand_addr", int'(ADDR), m_addr);
        chk("rand_mode", int'(MODE), m_mode);
        chk("rand_overflow", int'(OVERFLOW), m_ovf);
        chk("rand_nreads", rlog.size(), exp_r.size());
        for (int i = 0; i < exp_r.size() && i < rlog.size(); i++) chk("rand_read", rlog[i], exp_r[i]);
`ifdef VDP_READBACK_EN
        chk("rand_read_pulse", int'(max_run <= 1), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
